data_mem_master: RTL and testbench

DATA_MEM_MASTER -- requirements
Module: data_mem_master

---
 rtl/data_mem_master.sv | 186 ++++++++++++++++++
 tb/tb_data_mem_master.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_master.sv
// Load/store unit between a pipeline request port and a single-port word memory.
// Define DATA_MEM_MASTER_RMW_EN to enable read-modify-write for byte/halfword stores.
module data_mem_master #(
  parameter int  MEM_WIDTH = 32,
  parameter int  MEM_SIZE  = 256,
  localparam int AW        = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [31:0]          req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [MEM_WIDTH-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [MEM_WIDTH-1:0] mem_write_val,
  input  logic [MEM_WIDTH-1:0] mem_read_val
);

`ifdef DATA_MEM_MASTER_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_write;
  logic [1:0]           r_size;
  logic                 r_signed;
  logic [AW+1:0]        r_addr;
  logic [MEM_WIDTH-1:0] r_wdata;
  logic [MEM_WIDTH-1:0] r_rdata;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_err;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [MEM_WIDTH-1:0] w_load;
  logic [MEM_WIDTH-1:0] w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Rejection is decided from the live request so the FSM can branch straight to RESP.
  always_comb begin
    w_err = 1'b0;
    case (req_size)
      2'b00:   w_err = req_write && !RMW_EN;
      2'b01:   w_err = req_addr[0] || (req_write && !RMW_EN);
      2'b10:   w_err = (req_addr[1:0] != 2'b00);
      default: w_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_SIZE)) begin
      w_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err) begin
            w_state_next = S_RESP;
          end else if (req_write && (req_size == 2'b10)) begin
            w_state_next = S_WR;
          end else begin
            w_state_next = S_RD;
          end
        end
      end
      S_RD:    w_state_next = S_CAP;
      S_CAP:   w_state_next = r_write ? S_WR : S_RESP;
      S_WR:    w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr[AW+1:0];
        r_wdata  <= req_wdata;
        r_err    <= w_err;
      end
      // The memory has a registered read, so data addressed in RD is stable during CAP.
      if (r_state == S_CAP) begin
        r_rdata <= mem_read_val;
      end
    end
  end

  assign w_byte = r_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load = r_rdata;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_wdata;
    case (r_size)
      2'b00: begin
        w_merged = r_rdata;
        w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_merged = r_rdata;
        w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: w_merged = r_wdata;
    endcase
  end

  // Outputs decode from state alone so an asynchronous reset clears them at once.
  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_error    = 1'b0;
    resp_rdata    = '0;
    mem_addr      = '0;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_write_val = '0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_RD, S_CAP: begin
        mem_read_en = 1'b1;
        mem_addr    = r_addr[AW+1:2];
      end
      S_WR: begin
        mem_write_en  = 1'b1;
        mem_addr      = r_addr[AW+1:2];
        mem_write_val = w_merged;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_error = r_err;
        resp_rdata = (!r_err && !r_write) ? w_load : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboard bench for data_mem_master: byte-addressed reference model, word memory model,
// directed cases followed by randomized traffic and a mid-access reset.
module tb_data_mem_master;

`ifdef DATA_MEM_MASTER_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [7:0]  mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_write_val;
  logic [31:0] mem_read_val;

  always #5 clk = ~clk;

  data_mem_master #(.MEM_WIDTH(32), .MEM_SIZE(256)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
    .mem_read_val(mem_read_val)
  );

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
    int          nrd;
    int          nwr;
    logic [7:0]  waddr;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          txn = 0;
  logic [7:0]  ref_b [0:1023];
  logic [31:0] mem [0:255];
  logic [31:0] mem_rd;

  assign mem_read_val = mem_rd;

  function automatic logic [31:0] init_word(int i);
    logic [31:0] v;
    if (i == 0) return 32'h0000_0001;
    v = 32'(i) * 32'h9E37_79B9;
    return v ^ 32'h0F1E_2D3C;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_now();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Word memory with registered read
  initial begin
    mem_rd = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_en) mem[mem_addr] <= mem_write_val;
      if (mem_read_en) mem_rd <= mem[mem_addr];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: strobe bookkeeping every cycle, scoreboard pop on each response
  initial begin
    int rd_cnt;
    int wr_cnt;
    exp_t e;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_cnt = 0;
        wr_cnt = 0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_strobes", 32'({mem_read_en, mem_write_en}), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      end else begin
        chk("strobe_exclusive", 32'(mem_read_en & mem_write_en), 32'd0);
        if (mem_read_en || mem_write_en) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: got rd=%0b wr=%0b required none", mem_read_en, mem_write_en);
          end else begin
            chk("mem_addr", 32'(mem_addr), 32'(sbq[0].waddr));
          end
          if (mem_read_en) rd_cnt++;
          if (mem_write_en) wr_cnt++;
        end else begin
          chk("mem_addr_idle", 32'(mem_addr), 32'd0);
        end
        if (resp_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_resp: got resp_valid=1 required 0");
          end else begin
            e = sbq.pop_front();
            chk("resp_error", 32'(resp_error), 32'(e.err));
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("read_strobes", 32'(rd_cnt), 32'(e.nrd));
            chk("write_strobes", 32'(wr_cnt), 32'(e.nwr));
            txn++;
            $display("TXN %0d err=%0b rdata=%h lat=%0d rd=%0d wr=%0d",
                     txn, resp_error, resp_rdata, cyc - e.acc + 1, rd_cnt, wr_cnt);
          end
          rd_cnt = 0;
          wr_cnt = 0;
        end
      end
    end
  end

  // Issue one request; expectation comes from the byte model unless given explicitly.
  // commit=0 leaves the model untouched (used for an access that will be aborted).
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_exp, input bit x_err,
                       input logic [31:0] x_rd, input bit commit);
    exp_t   e;
    int     n;
    int     nb;
    bit     m_err;
    longint v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
            ((a >> 2) >= 32'd256) || (w && sz != 2'd2 && !RMW);
    v = 0;
    if (!m_err && !w) begin
      for (int k = 0; k < nb; k++) v = v | (longint'(ref_b[int'(a) + k]) << (8 * k));
      if (sg && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
    end
    e.err   = use_exp ? x_err : m_err;
    e.rdata = use_exp ? x_rd : v[31:0];
    e.lat   = m_err ? 1 : (!w ? 3 : (sz == 2'd2 ? 2 : 4));
    e.nrd   = (m_err || (w && sz == 2'd2)) ? 0 : 2;
    e.nwr   = (!m_err && w) ? 1 : 0;
    e.waddr = a[9:2];
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got req_ready=0 required 1");
      finish_now();
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    if (commit && w && !m_err) begin
      for (int k = 0; k < nb; k++) ref_b[int'(a) + k] = 8'(wd >> (8 * k));
    end
    // Noise while busy; the block must ignore it
    req_valid  = 1'($urandom_range(0, 1));
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending required 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    checks++;
    failures++;
    $display("FAIL watchdog: got timeout required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx;
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) ref_b[4*i + k] = 8'(init_word(i) >> (8 * k));
    end
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_write_val", mem_write_val, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    issue(1'b0, 2'd2, 1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 32'h0000_0001, 1'b1);
    issue(1'b1, 2'd2, 1'b0, 32'h40,  32'h80FF, 1'b1, 1'b0, 32'h0,         1'b1);
    issue(1'b0, 2'd0, 1'b1, 32'h40,  32'h0,    1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h40,  32'h0,    1'b1, 1'b0, 32'h0000_80FF, 1'b1);
    issue(1'b1, 2'd0, 1'b0, 32'h41,  32'hAB,   1'b1, !RMW, 32'h0,         1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h40,  32'h0,    1'b1, 1'b0, RMW ? 32'h0000_ABFF : 32'h0000_80FF, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h3,   32'h0,    1'b1, 1'b1, 32'h0,         1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h402, 32'h0,    1'b1, 1'b1, 32'h0,         1'b1);
    issue(1'b0, 2'd3, 1'b0, 32'h40,  32'h0,    1'b1, 1'b1, 32'h0,         1'b1);
    drain();

    // Reset while in CAP: strobes drop at once, no response, memory untouched
    if (RMW) issue(1'b1, 2'd0, 1'b0, 32'h42, 32'h5A, 1'b1, 1'b0, 32'h0, 1'b0);
    else     issue(1'b0, 2'd2, 1'b0, 32'h44, 32'h0,  1'b1, 1'b0, 32'h0, 1'b0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("cap_read_en", 32'(mem_read_en), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_read_en", 32'(mem_read_en), 32'd0);
    chk("abort_write_en", 32'(mem_write_en), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    chk("abort_write_val", mem_write_val, 32'h0);
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, RMW ? 32'h0000_ABFF : 32'h0000_80FF, 1'b1);
    drain();

    for (int t = 0; t < 300; t++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      idx = ($urandom_range(0, 19) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 63);
      a = {idx[29:0], 2'($urandom_range(0, 3))};
      if (sz != 2'd0 && $urandom_range(0, 3) != 0) a[1:0] = (sz == 2'd1) ? {a[1], 1'b0} : 2'b00;
      if ($urandom_range(0, 49) == 0) a[31] = 1'b1;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
            1'b0, 1'b0, 32'h0, 1'b1);
    end
    drain();

    for (int i = 0; i < 256; i++) begin
      chk("final_mem", mem[i], {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]});
    end
    finish_now();
  end

endmodule
